// File: rtl/bus_gnrtr_n_rbtr.sv
// rtl/bus_gnrtr_n_rbtr.sv - round-robin shared-bus arbiter/forwarder, one FSM per bus
// Pops one packet from a pending egress FIFO and pushes it to the addressed ingress FIFO(s).
module bus_gnrtr_n_rbtr #(
  parameter int       bits      = 1,
  parameter int       drvrs     = 4,
  parameter int       pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [bits-1:0][drvrs-1:0]                pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [bits-1:0][drvrs-1:0]                pop,
  output logic [bits-1:0][drvrs-1:0]                push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_push
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {S_IDLE, S_POP, S_PUSH} state_t;

  for (genvar b = 0; b < bits; b++) begin : g_bus
    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      win_q, win_d;
    logic [drvrs-1:0]   pop_q, pop_d;
    logic [drvrs-1:0]   push_q, push_d;
    logic [pckg_sz-1:0] pkt_q, pkt_d;
    logic               found;
    logic [IW-1:0]      pick;
    logic [7:0]         id;

    // First pending device at or after the pointer, wrapping around.
    always_comb begin
      int idx;
      found = 1'b0;
      pick  = ptr_q;
      for (int i = 0; i < drvrs; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= drvrs) idx = idx - drvrs;
        if (!found && pndng[b][idx]) begin
          found = 1'b1;
          pick  = IW'(idx);
        end
      end
    end

    assign id = D_pop[b][win_q][pckg_sz-1 -: 8];

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= S_IDLE;
        ptr_q   <= '0;
        win_q   <= '0;
        pop_q   <= '0;
        push_q  <= '0;
        pkt_q   <= '0;
      end else begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        win_q   <= win_d;
        pop_q   <= pop_d;
        push_q  <= push_d;
        pkt_q   <= pkt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        S_IDLE:  if (found) state_d = S_POP;
        S_POP:   state_d = S_PUSH;
        S_PUSH:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are computed one cycle ahead and registered above.
    always_comb begin
      pop_d  = '0;
      push_d = '0;
      pkt_d  = pkt_q;
      ptr_d  = ptr_q;
      win_d  = win_q;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            pop_d[pick] = 1'b1;
            win_d       = pick;
          end
        end
        S_POP: begin
          pkt_d = D_pop[b][win_q];
          for (int j = 0; j < drvrs; j++) begin
            if (id == broadcast) push_d[j] = (j != int'(win_q));
            else                 push_d[j] = (int'(id) == j);
          end
        end
        S_PUSH: begin
          ptr_d = (int'(win_q) == drvrs - 1) ? '0 : win_q + IW'(1);
        end
        default: ;
      endcase
    end

    assign pop[b]  = pop_q;
    assign push[b] = push_q;
    for (genvar j = 0; j < drvrs; j++) begin : g_dpush
      assign D_push[b][j] = pkt_q;
    end
  end

endmodule

// File: tb/tb_bus_gnrtr_n_rbtr.sv
// tb/tb_bus_gnrtr_n_rbtr.sv - directed and random transfers against a rule-level model
module tb_bus_gnrtr_n_rbtr;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [0:0][3:0]        pndng;
  logic [0:0][3:0][15:0]  D_pop;
  logic [0:0][3:0]        pop;
  logic [0:0][3:0]        push;
  logic [0:0][3:0][15:0]  D_push;

  int errors = 0;
  int checks = 0;
  int ptr_m  = 0;
  logic [15:0] last_pkt = '0;

  bus_gnrtr_n_rbtr #(.bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int arb(input int p, input logic [3:0] pend);
    for (int k = 0; k < 4; k++)
      if (pend[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_push(input logic [15:0] pk, input int w);
    int id;
    id = int'(pk[15:8]);
    if (id == 255) return 4'hF & ~(4'(1) << w);
    if (id < 4) return 4'(1) << id;
    return 4'h0;
  endfunction

  function automatic logic [15:0] rnd_pkt();
    int sel;
    logic [7:0] id;
    sel = int'($urandom_range(0, 5));
    if (sel < 4)       id = 8'(sel);
    else if (sel == 4) id = 8'hFF;
    else               id = 8'($urandom_range(4, 254));
    return {id, 8'($urandom)};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One arbitration window: pop, push, then back to idle.
  task automatic xfer(input logic [3:0] pend, input logic [3:0][15:0] pk);
    int w;
    logic [15:0] pkt;
    pndng = pend;
    D_pop = pk;
    w = arb(ptr_m, pend);
    step();
    if (w < 0) begin
      chk("idle_pop", pop, 0);
      chk("idle_push", push, 0);
      chk("idle_dpush", D_push, {4{last_pkt}});
      return;
    end
    chk("pop", pop, 64'(1) << w);
    chk("pop_cycle_push", push, 0);
    pkt = pk[w];
    pndng = 4'($urandom);
    step();
    D_pop = {$urandom, $urandom};
    chk("push", push, exp_push(pkt, w));
    chk("push_cycle_pop", pop, 0);
    chk("dpush", D_push, {4{pkt}});
    step();
    chk("post_push", push, 0);
    chk("post_pop", pop, 0);
    chk("dpush_hold", D_push, {4{pkt}});
    ptr_m = (w + 1) % 4;
    last_pkt = pkt;
  endtask

  initial begin
    logic [3:0][15:0] pk;
    reset = 1'b1;
    pndng = 4'hF;
    D_pop = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_pop", pop, 0);
      chk("rst_push", push, 0);
      chk("rst_dpush", D_push, 0);
    end
    reset = 1'b0;

    // Round-robin: everyone pending, all addressed to device 0.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) pk[j] = {8'h00, 8'($urandom)};
      xfer(4'hF, pk);
    end

    pk = {4{16'h0000}};
    pk[1] = 16'h03A5;
    xfer(4'b0010, pk);
    pk = {4{16'h0000}};
    pk[2] = 16'hFF5A;
    xfer(4'b0100, pk);
    pk = {4{16'h0000}};
    pk[0] = 16'h075A;
    xfer(4'b0001, pk);
    for (int j = 0; j < 4; j++) pk[j] = rnd_pkt();
    xfer(4'hF, pk);

    // Reset while pop is high aborts the transfer.
    for (int j = 0; j < 4; j++) pk[j] = 16'h0111;
    pndng = 4'b1000;
    D_pop = pk;
    step();
    chk("mid_pop", pop, 4'b1000);
    reset = 1'b1;
    step();
    chk("mid_rst_push", push, 0);
    chk("mid_rst_pop", pop, 0);
    reset = 1'b0;
    pndng = 4'h0;
    step();
    chk("after_rst_push", push, 0);
    chk("after_rst_dpush", D_push, 0);
    ptr_m = 0;
    last_pkt = '0;
    for (int j = 0; j < 4; j++) pk[j] = rnd_pkt();
    xfer(4'hF, pk);

    for (int i = 0; i < 60; i++) begin
      for (int j = 0; j < 4; j++) pk[j] = rnd_pkt();
      xfer(($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom), pk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
